tdm_demux: RTL and testbench

Receive end of the team's time-division multiplexed serial link. The TDM mux on the far end serialises CHANNELS words of WIDTH bits into one frame, marked by a frame-sync strobe. This block locks to the sync, counts bit and slot position, and deserialises each slot into a per-channel output register with a one-cycle valid pulse. It sits between the link pin logic and the per-channel consumers.

---
 rtl/tdm_demux.sv | 138 +++++++++++++
 tb/tb_tdm_demux.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Receive side of the TDM serial link: locks to the frame sync, tracks bit/slot
// position and deserialises each MSB-first slot into its own channel register.
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din,
    input  logic                         en,
    input  logic                         sync,
    output logic [CHANNELS*WIDTH-1:0]    o,
    output logic [CHANNELS-1:0]          o_valid,
    output logic                         frame_done,
    output logic                         sync_err,
    output logic                         locked,
    output logic                         o_dbg_state
);
    localparam int BW = $clog2(WIDTH);
    localparam int SW = $clog2(CHANNELS);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [BW-1:0]              r_bit_cnt;
    logic [BW-1:0]              w_bit_cnt_next;
    logic [SW-1:0]              r_slot_cnt;
    logic [SW-1:0]              w_slot_cnt_next;
    // Only WIDTH-1 earlier bits are stored; the final bit of a slot comes straight from din.
    logic [WIDTH-2:0]           r_shift;
    logic [WIDTH-2:0]           w_shift_next;
    logic [WIDTH-1:0]           w_shift_in;
    logic [CHANNELS*WIDTH-1:0]  r_o;
    logic [CHANNELS*WIDTH-1:0]  w_o_next;
    logic [CHANNELS-1:0]        r_valid;
    logic [CHANNELS-1:0]        w_valid_next;
    logic                       r_frame_done;
    logic                       w_frame_done_next;
    logic                       r_sync_err;
    logic                       w_sync_err_next;
    logic                       w_at_boundary;
    logic                       w_last_bit;
    logic                       w_last_slot;

    assign w_shift_in    = {r_shift, din};
    assign w_at_boundary = (r_bit_cnt == '0) && (r_slot_cnt == '0);
    assign w_last_bit    = (r_bit_cnt == BW'(WIDTH - 1));
    assign w_last_slot   = (r_slot_cnt == SW'(CHANNELS - 1));

    always_comb begin
        w_state_next      = r_state;
        w_bit_cnt_next    = r_bit_cnt;
        w_slot_cnt_next   = r_slot_cnt;
        w_shift_next      = r_shift;
        w_o_next          = r_o;
        w_valid_next      = '0;
        w_frame_done_next = 1'b0;
        w_sync_err_next   = 1'b0;
        if (en) begin
            case (r_state)
                HUNT: begin
                    if (sync) begin
                        w_shift_next    = '0;
                        w_shift_next[0] = din;
                        w_bit_cnt_next  = BW'(1);
                        w_slot_cnt_next = '0;
                        w_state_next    = LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_at_boundary && !sync) begin
                        // Missing sync: drop the bit and go back to hunting.
                        w_sync_err_next = 1'b1;
                        w_bit_cnt_next  = '0;
                        w_slot_cnt_next = '0;
                        w_state_next    = HUNT;
                    end else if (!w_at_boundary && sync) begin
                        // Early sync: abandon the partial slot and restart the frame here.
                        w_sync_err_next = 1'b1;
                        w_shift_next    = '0;
                        w_shift_next[0] = din;
                        w_bit_cnt_next  = BW'(1);
                        w_slot_cnt_next = '0;
                    end else begin
                        w_shift_next = w_shift_in[WIDTH-2:0];
                        if (w_last_bit) begin
                            w_bit_cnt_next    = '0;
                            w_slot_cnt_next   = w_last_slot ? '0 : r_slot_cnt + SW'(1);
                            w_frame_done_next = w_last_slot;
                            for (int k = 0; k < CHANNELS; k++) begin
                                if (r_slot_cnt == SW'(k)) begin
                                    w_o_next[k*WIDTH +: WIDTH] = w_shift_in;
                                    w_valid_next[k]            = 1'b1;
                                end
                            end
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + BW'(1);
                        end
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HUNT;
            r_bit_cnt    <= '0;
            r_slot_cnt   <= '0;
            r_shift      <= '0;
            r_o          <= '0;
            r_valid      <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_slot_cnt   <= w_slot_cnt_next;
            r_shift      <= w_shift_next;
            r_o          <= w_o_next;
            r_valid      <= w_valid_next;
            r_frame_done <= w_frame_done_next;
            r_sync_err   <= w_sync_err_next;
        end
    end

    assign o           = r_o;
    assign o_valid     = r_valid;
    assign frame_done  = r_frame_done;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == LOCKED);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios from the test plan plus a
// randomized run, all against a frame-position reference model.
module tb_tdm_demux;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int CW = CH * W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           din = 1'b0;
    logic           en = 1'b0;
    logic           sync = 1'b0;
    logic [CW-1:0]  o;
    logic [CH-1:0]  o_valid;
    logic           frame_done;
    logic           sync_err;
    logic           locked;
    logic           o_dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: lock flag, absolute bit position inside the frame, word accumulator.
    bit             m_locked;
    int             m_pos;
    int             m_word;
    logic [W-1:0]   m_o [CH];
    logic [CH-1:0]  m_valid;
    bit             m_fd;
    bit             m_err;

    // Observation counters, cleared by each scenario.
    int             obs_mism;
    int             obs_err;
    int             obs_fd;
    int             obs_valid;
    logic [W-1:0]   exp_q[$];

    tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .en          (en),
        .sync        (sync),
        .o           (o),
        .o_valid     (o_valid),
        .frame_done  (frame_done),
        .sync_err    (sync_err),
        .locked      (locked),
        .o_dbg_state (o_dbg_state)
    );

    always #5 clk = ~clk;

    function automatic void model_step(input bit d, input bit s, input bit e, input bit r);
        int slot;
        m_valid = '0;
        m_fd    = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_pos    = 0;
            m_word   = 0;
            for (int k = 0; k < CH; k++) m_o[k] = '0;
            return;
        end
        if (!e) return;
        if (!m_locked) begin
            if (s) begin
                m_locked = 1'b1;
                m_pos    = 1;
                m_word   = int'(d);
            end
            return;
        end
        if (m_pos == 0 && !s) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
            return;
        end
        if (m_pos != 0 && s) begin
            m_err  = 1'b1;
            m_pos  = 1;
            m_word = int'(d);
            return;
        end
        m_word = m_word * 2 + int'(d);
        if (m_pos % W == W - 1) begin
            slot          = m_pos / W;
            m_o[slot]     = m_word[W-1:0];
            m_valid[slot] = 1'b1;
            m_fd          = (slot == CH - 1);
            m_word        = 0;
        end
        m_pos = (m_pos + 1) % CW;
    endfunction

    function automatic logic [CW-1:0] model_o();
        logic [CW-1:0] v;
        for (int k = 0; k < CH; k++) v[k*W +: W] = m_o[k];
        return v;
    endfunction

    // Apply one cycle of inputs, advance the model, and log any divergence after the edge.
    task automatic drive(input logic d, input logic s, input logic e, input logic r);
        logic [CW-1:0] exp_o;
        logic [W-1:0]  w;
        @(negedge clk);
        din  = d;
        sync = s;
        en   = e;
        rst  = r;
        model_step(d, s, e, r);
        @(posedge clk);
        #1;
        exp_o = model_o();
        if ({o, o_valid, frame_done, sync_err, locked} !== {exp_o, m_valid, m_fd, m_err, m_locked}) begin
            obs_mism++;
            $display("  diff t=%0t o=%h/%h v=%b/%b fd=%b/%b err=%b/%b lk=%b/%b", $time,
                     o, exp_o, o_valid, m_valid, frame_done, m_fd, sync_err, m_err, locked, m_locked);
        end
        for (int k = 0; k < CH; k++) if (m_valid[k]) exp_q.push_back(m_o[k]);
        for (int k = 0; k < CH; k++) begin
            if (o_valid[k] === 1'b1) begin
                obs_valid++;
                if (exp_q.size() == 0) begin
                    obs_mism++;
                end else begin
                    w = exp_q.pop_front();
                    if (w !== o[k*W +: W]) obs_mism++;
                end
            end
        end
        if (sync_err === 1'b1) obs_err++;
        if (frame_done === 1'b1) obs_fd++;
    endtask

    function automatic logic frame_bit(input logic [CW-1:0] vec, input int i);
        return vec[(i / W) * W + (W - 1 - i % W)];
    endfunction

    task automatic clear_obs();
        obs_mism  = 0;
        obs_err   = 0;
        obs_fd    = 0;
        obs_valid = 0;
    endtask

    task automatic send_bits(input logic [CW-1:0] vec, input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) drive(1'($urandom), 1'($urandom), 1'b0, 1'b0);
            drive(frame_bit(vec, i), (i == 0), 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        clear_obs();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_o got %h exp 0", o); end
        checks++;
        if ({o_valid, frame_done, sync_err} !== '0) begin
            errors++; $display("FAIL reset_pulses got %b exp 0", {o_valid, frame_done, sync_err});
        end
        checks++;
        if (locked !== 1'b0 || o_dbg_state !== 1'b0) begin
            errors++; $display("FAIL reset_state locked=%b state=%b exp 0/0", locked, o_dbg_state);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_idle locked=%b exp 0", locked); end
    endtask

    task automatic test_single_frame();
        logic [CW-1:0] vec = 32'h00FF3CA5;
        clear_obs();
        for (int i = 0; i < CW; i++) begin
            drive(frame_bit(vec, i), (i == 0), 1'b1, 1'b0);
            if (i % W == W - 1) begin
                checks++;
                if (o_valid !== CH'(1 << (i / W)) || frame_done !== (i == CW - 1)) begin
                    errors++;
                    $display("FAIL frame_pulse bit %0d valid=%b fd=%b exp %b/%b", i, o_valid,
                             frame_done, CH'(1 << (i / W)), (i == CW - 1));
                end
            end
        end
        checks++;
        if (o !== 32'h00FF3CA5) begin errors++; $display("FAIL frame_o got %h exp 00ff3ca5", o); end
        checks++;
        if (locked !== 1'b1 || o_dbg_state !== 1'b1 || obs_err != 0) begin
            errors++; $display("FAIL frame_lock locked=%b errs=%0d exp 1/0", locked, obs_err);
        end
        checks++;
        if (obs_mism != 0) begin errors++; $display("FAIL frame_model diffs=%0d exp 0", obs_mism); end
    endtask

    task automatic test_gaps();
        logic [CW-1:0] vec = 32'h00FF3CA5;
        int            gap_pulses = 0;
        clear_obs();
        for (int i = 0; i < CW; i++) begin
            drive(1'($urandom), 1'($urandom), 1'b0, 1'b0);
            if (o_valid !== '0 || frame_done !== 1'b0) gap_pulses++;
            drive(frame_bit(vec, i), (i == 0), 1'b1, 1'b0);
            if (i % W == W - 1) begin
                checks++;
                if (o_valid !== CH'(1 << (i / W))) begin
                    errors++; $display("FAIL gaps_pulse bit %0d valid=%b exp %b", i, o_valid, CH'(1 << (i / W)));
                end
            end
        end
        checks++;
        if (gap_pulses != 0) begin errors++; $display("FAIL gaps_idle pulses=%0d exp 0", gap_pulses); end
        checks++;
        if (o !== 32'h00FF3CA5 || obs_fd != 1 || obs_err != 0) begin
            errors++; $display("FAIL gaps_o got %h fd=%0d err=%0d exp 00ff3ca5/1/0", o, obs_fd, obs_err);
        end
        checks++;
        if (obs_mism != 0) begin errors++; $display("FAIL gaps_model diffs=%0d exp 0", obs_mism); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_bits(32'h00FF3CA5, 0, CW - 1, 1'b0);
        send_bits(32'h44332211, 0, CW - 1, 1'b0);
        checks++;
        if (o !== 32'h44332211 || obs_fd != 2 || obs_err != 0 || obs_valid != 2 * CH) begin
            errors++;
            $display("FAIL b2b got %h fd=%0d err=%0d v=%0d exp 44332211/2/0/8", o, obs_fd, obs_err, obs_valid);
        end
        checks++;
        if (obs_mism != 0) begin errors++; $display("FAIL b2b_model diffs=%0d exp 0", obs_mism); end
    endtask

    task automatic test_early_sync();
        clear_obs();
        send_bits(32'hDEADBEEF, 0, 11, 1'b0);
        checks++;
        if (o !== 32'h443322EF || obs_valid != 1) begin
            errors++; $display("FAIL early_pre got %h v=%0d exp 443322ef/1", o, obs_valid);
        end
        drive(frame_bit(32'h78563412, 0), 1'b1, 1'b1, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || o !== 32'h443322EF || locked !== 1'b1) begin
            errors++; $display("FAIL early_err err=%b o=%h lk=%b exp 1/443322ef/1", sync_err, o, locked);
        end
        send_bits(32'h78563412, 1, CW - 1, 1'b0);
        checks++;
        if (o !== 32'h78563412 || obs_err != 1 || obs_fd != 1) begin
            errors++; $display("FAIL early_post got %h err=%0d fd=%0d exp 78563412/1/1", o, obs_err, obs_fd);
        end
        checks++;
        if (obs_mism != 0) begin errors++; $display("FAIL early_model diffs=%0d exp 0", obs_mism); end
    endtask

    task automatic test_missing_sync();
        clear_obs();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL miss_err err=%b lk=%b exp 1/0", sync_err, locked);
        end
        for (int i = 0; i < 12; i++) drive(1'($urandom), 1'b0, 1'b1, 1'b0);
        checks++;
        if (o !== 32'h78563412 || locked !== 1'b0 || obs_err != 1 || obs_valid != 0) begin
            errors++;
            $display("FAIL miss_hunt o=%h lk=%b err=%0d v=%0d exp 78563412/0/1/0", o, locked, obs_err, obs_valid);
        end
        send_bits(32'hC0FFEE01, 0, CW - 1, 1'b1);
        checks++;
        if (o !== 32'hC0FFEE01 || locked !== 1'b1 || obs_fd != 1) begin
            errors++; $display("FAIL miss_resync got %h lk=%b fd=%0d exp c0ffee01/1/1", o, locked, obs_fd);
        end
        checks++;
        if (obs_mism != 0) begin errors++; $display("FAIL miss_model diffs=%0d exp 0", obs_mism); end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        send_bits(32'h13579BDF, 0, 19, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({o, o_valid, frame_done, sync_err, locked} !== '0) begin
            errors++; $display("FAIL midrst got o=%h v=%b fd=%b err=%b lk=%b exp all 0",
                               o, o_valid, frame_done, sync_err, locked);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_valid, frame_done, sync_err, locked} !== '0) begin
            errors++; $display("FAIL midrst_quiet got %b exp 0", {o_valid, frame_done, sync_err, locked});
        end
        send_bits(32'h2468ACE0, 0, CW - 1, 1'b0);
        checks++;
        if (o !== 32'h2468ACE0 || obs_err != 0) begin
            errors++; $display("FAIL midrst_frame got %h err=%0d exp 2468ace0/0", o, obs_err);
        end
        checks++;
        if (obs_mism != 0) begin errors++; $display("FAIL midrst_model diffs=%0d exp 0", obs_mism); end
    endtask

    task automatic test_random();
        bit s;
        int multi = 0;
        clear_obs();
        exp_q.delete();
        for (int n = 0; n < 1500; n++) begin
            if (m_locked) s = (m_pos == 0);
            else          s = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) s = !s;
            drive(1'($urandom), s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
            if ($countones(o_valid) > 1) multi++;
        end
        checks++;
        if (multi != 0) begin errors++; $display("FAIL rand_onehot cycles=%0d exp 0", multi); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rand_queue left=%0d exp 0", exp_q.size()); end
        checks++;
        if (obs_mism != 0) begin errors++; $display("FAIL rand_model diffs=%0d exp 0", obs_mism); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gaps();
        test_back_to_back();
        test_early_sync();
        test_missing_sync();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
